// File: rtl/jtmikie_snd_pkg.sv
// Shared types and constants for the main-to-sound command latch.
// Imported by the sound latch top and its helpers.
package jtmikie_snd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } snd_st_t;

  localparam logic [7:0] OVR_MAX = 8'hFF;

endpackage

// File: rtl/jtmikie_sync2.sv
// Two-flop synchronizer, parameterized width.
// Both stages clear to zero on reset.
module jtmikie_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtmikie_sndlatch.sv
// Sound-side command latch: synchronizes main CPU writes, queues them,
// raises the sound CPU interrupt until acknowledge and serves reads.
module jtmikie_sndlatch
  import jtmikie_snd_pkg::*;
#(
  parameter int AW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  main_latch,
  input  logic        m2s_on,
  input  logic        rd,
  input  logic        irq_ack,
  output logic [7:0]  dout,
  output logic        int_n,
  output logic [AW:0] level,
  output logic [7:0]  ovr_cnt
);

  localparam int DEPTH = 1 << AW;
  localparam int PW    = (AW == 0) ? 1 : AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (AW == 0) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    if (AW == 0) return '0;
    return p - 1'b1;
  endfunction

  logic          s2, s2_d, armed;
  logic [1:0]    flush;
  logic [7:0]    lat;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  snd_st_t       st;

  jtmikie_sync2 #(.W(1)) u_stb (
    .clk (clk),
    .rst (rst),
    .d   (m2s_on),
    .q   (s2)
  );

  jtmikie_sync2 #(.W(8)) u_dat (
    .clk (clk),
    .rst (rst),
    .d   (main_latch),
    .q   (lat)
  );

  logic          ev, pop, full, more;
  logic [PW-1:0] widx, wr_n, rd_n;
  logic [AW:0]   lvl_n;
  logic [7:0]    dout_n;
  snd_st_t       st_n;

  always_comb begin
    ev     = s2 & ~s2_d & armed;
    pop    = rd & (level != '0);
    full   = (level == FULL_LVL) & ~pop;
    widx   = full ? ptr_dec(wr_ptr) : wr_ptr;
    wr_n   = (ev && !full) ? ptr_inc(wr_ptr) : wr_ptr;
    rd_n   = pop ? ptr_inc(rd_ptr) : rd_ptr;
    lvl_n  = level;
    if (ev && !full && !pop) lvl_n = level + 1'b1;
    if (pop && !ev) lvl_n = level - 1'b1;
    more   = pop && (lvl_n != '0);
    dout_n = dout;
    if (lvl_n != '0) dout_n = (ev && widx == rd_n) ? lat : mem[rd_n];
    st_n   = st;
    unique case (st)
      IDLE: if (ev || more) st_n = REQ;
      REQ:  if (irq_ack && !ev && !more) st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ev) mem[widx] <= lat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_d    <= 1'b0;
      flush   <= 2'b00;
      armed   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ovr_cnt <= 8'h00;
      dout    <= 8'h00;
      st      <= IDLE;
      int_n   <= 1'b1;
    end else begin
      s2_d   <= s2;
      flush  <= {flush[0], 1'b1};
      // s2 only mirrors the pin once the reset zeros have drained out
      if (flush[1] && !s2) armed <= 1'b1;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      level  <= lvl_n;
      dout   <= dout_n;
      if (ev && full && ovr_cnt != OVR_MAX) ovr_cnt <= ovr_cnt + 8'd1;
      st     <= st_n;
      int_n  <= (st_n != REQ);
    end
  end

endmodule

// File: doc/jtmikie_sndlatch.md
# jtmikie_sndlatch

Sound-side responder for the main-to-sound command channel. The main CPU drives `snd_latch` and pulses `snd_on`; this block captures each command in the sound clock domain, queues it, holds the sound CPU interrupt line until acknowledge, and serves reads of the queued byte. It sits inside the sound subsystem between the main CPU's latch outputs and the sound Z80, replacing the bare register-plus-flip-flop.

## Interface

Clock is `clk`; reset is `rst`, synchronous, active-high.

**Parameters**
- `AW`, default 0: queue address width. Depth is 2^AW entries, so 0 gives the single hardware latch. Legal range is 0 to 3.

**Ports**
- `clk`, input, 1 bit: sound clock (48 MHz).
- `rst`, input, 1 bit: synchronous reset, active-high.
- `main_latch`, input, 8 bits: command byte from the main CPU. It is asynchronous (clk24 domain) and is stable from before `m2s_on` rises until after it falls.
- `m2s_on`, input, 1 bit: command strobe from the main CPU. It is asynchronous, and a rising edge means a write.
- `rd`, input, 1 bit: 1-cycle pulse when the sound CPU reads the latch port.
- `irq_ack`, input, 1 bit: 1-cycle pulse on the sound CPU interrupt acknowledge (M1 and IORQ).
- `dout`, output, 8 bits: current command byte. Reset value is 0x00.
- `int_n`, output, 1 bit: sound CPU interrupt, active-low. Reset value is 1.
- `level`, output, AW+1 bits: number of unread entries. Reset value is 0.
- `ovr_cnt`, output, 8 bits: overrun counter that saturates at 0xFF. Reset value is 0.

## Operation

**Synchronizer**
- `m2s_on` passes through a 2-flop synchronizer (`s1`, `s2`). Both flops reset to 0.
- A write event fires when `s2` is 1, the previous `s2` is 0, and the block is `armed`.
- `armed` resets to 0 and sets on the first cycle where `s2` is 0. A strobe already high at reset release therefore never generates an event.
- `main_latch` is sampled through its own 2-flop stage, aligned with `s2`. The byte pushed is the sampled value on the event cycle.

**Queue**
- The queue is a circular buffer with 2^AW entries, a write pointer and a read pointer (each AW bits), and a count `level`.
- Push on an event:
  - If `level` is less than 2^AW, write at the write pointer, then increment the write pointer and `level`.
  - If full, overwrite the most recently written entry, leave `level` unchanged, and increment `ovr_cnt` (saturating).
  - With AW = 0, this reproduces the hardware latch: the last write wins.
- `dout`:
  - When `level` > 0, `dout` is the head entry.
  - When `level` is 0, `dout` holds the last head value (the latch retains its value). It does not return to 0.
- Pop on `rd`: when `level` > 0, increment the read pointer and decrement `level`. When `level` is 0, `rd` is ignored.
- Push and pop in the same cycle:
  - With `level` > 0, both happen and `level` is unchanged.
  - With `level` = 0, the pop is ignored and the push proceeds.

**Interrupt state machine** (states IDLE and REQ; `int_n` = 0 only in REQ)
- IDLE to REQ on a write event.
- REQ to IDLE on `irq_ack`, unless a write event occurs in the same cycle. In that case the machine stays in REQ.
- IDLE to REQ on a `rd` that leaves `level` > 0 after the pop, so each queued entry raises its own interrupt.
- The machine ignores `irq_ack` in IDLE.

**Reset mid-operation**
- Reset clears the pointers, `level`, `ovr_cnt`, `dout`, the synchronizer, and `armed`, and forces IDLE.
- Any command in flight is lost.

## Timing

- Latency from the `m2s_on` rising edge (sampled by `clk`) to the event is 2 cycles. Queue write and `int_n` falling are registered on the following edge, so the total is 3 `clk` cycles.
- `dout` is valid on the same edge that `int_n` falls.
- `int_n` rises 1 cycle after `irq_ack`.
- After a pop, the new `dout` and `level` are visible 1 cycle after `rd`.
- The minimum distinguishable strobe spacing is 2 `clk` cycles high and 2 cycles low. Narrower strobes may be lost; no recovery is required.

## Structure

- Package `jtmikie_snd_pkg` holds:
  - the state enum (IDLE, REQ);
  - constant `OVR_MAX` = 8'hFF.
- Sub-module `jtmikie_sync2` is a reusable 2-flop synchronizer, parameterized width, reset to 0. Instantiate it twice: once for the strobe (width 1) and once for the data (width 8).
- Everything else (queue, state machine, counters) stays in one module.

## Test plan

- Single command, AW = 0: `main_latch` = 0x5A, `m2s_on` high for 8 cycles. Expected: 3 cycles later `int_n` = 0, `dout` = 0x5A, `level` = 1. After `irq_ack`, `int_n` = 1 on the next cycle. After `rd`, `level` = 0 and `dout` stays 0x5A.
- Overrun, AW = 0: write 0x11 then 0x22 without `rd`. Expected: `dout` = 0x22, `level` = 1, `ovr_cnt` = 1. After 300 further writes, `ovr_cnt` = 0xFF.
- Queue, AW = 2:
  - Write 0x01, 0x02, 0x03, 0x04, 0x05. Expected: `level` = 4, `ovr_cnt` = 1, entries read back as 0x01, 0x02, 0x03, 0x05.
  - On each `rd` plus `irq_ack` cycle, `int_n` reasserts until `level` = 0.
- Simultaneous events:
  - `irq_ack` coincides with a write event: `int_n` stays 0.
  - `rd` and push coincide at `level` = 2: `level` stays 2.
  - Push at `level` = 0 with `rd`: `level` = 1.
- Reset:
  - Hold `m2s_on` = 1 through `rst` and for 10 cycles after. Expected: no event and `int_n` = 1.
  - Drop and re-raise `m2s_on`. Expected: an event fires.
  - Assert `rst` while in REQ with `level` = 3. Expected: all outputs return to their reset values on the next cycle.
- Narrow strobe: 2 cycles high and 2 cycles low, repeated 4 times with AW = 2. Expected: exactly 4 events.
